// File: rtl/drc_axi_burst_writer.sv
// rtl/drc_axi_burst_writer.sv - round-robin AXI4 INCR burst writer draining per-path descriptor/data FIFOs
// One burst in flight at a time; BRESP errors latch into err_bresp until reset.
module drc_axi_burst_writer #(
  parameter int P_PATHS = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [P_PATHS-1:0]     paths_burst_empty,
  input  logic [40*P_PATHS-1:0]  paths_burst_in,
  output logic [P_PATHS-1:0]     paths_burst_rd,
  input  logic [P_PATHS-1:0]     paths_data_empty,
  input  logic [128*P_PATHS-1:0] paths_data_in,
  input  logic [4*P_PATHS-1:0]   paths_data_dwen,
  output logic [P_PATHS-1:0]     paths_data_rd,
  output logic [31:0]            awaddr,
  output logic [7:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic [3:0]             awcache,
  output logic [2:0]             awproto,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [127:0]           wdata,
  output logic [15:0]            wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready,
  output logic                   busy,
  output logic                   err_bresp
);

  localparam int SEL_W = (P_PATHS > 1) ? $clog2(P_PATHS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] rr_nxt;
  logic             grant_found;
  logic [39:0]      grant_desc;
  logic [31:0]      addr_q;
  logic [7:0]       len_q;
  logic [7:0]       beat_cnt;
  logic             data_avail;
  logic [127:0]     data_sel;
  logic [3:0]       dwen_sel;
  logic             last_beat;
  logic             w_fire;

  // Descending offset so the path closest to rr_ptr is written last and wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_desc  = '0;
    for (int j = P_PATHS - 1; j >= 0; j--) begin
      for (int i = 0; i < P_PATHS; i++) begin
        if (!paths_burst_empty[i] && (i == (int'(rr_ptr) + j) % P_PATHS)) begin
          grant_found = 1'b1;
          grant_idx   = SEL_W'(i);
          grant_desc  = paths_burst_in[40*i +: 40];
        end
      end
    end
  end

  assign rr_nxt = SEL_W'((int'(grant_idx) + 1) % P_PATHS);

  always_comb begin
    data_sel   = '0;
    dwen_sel   = '0;
    data_avail = 1'b0;
    for (int i = 0; i < P_PATHS; i++) begin
      if (sel == SEL_W'(i)) begin
        data_sel   = paths_data_in[128*i +: 128];
        dwen_sel   = paths_data_dwen[4*i +: 4];
        data_avail = !paths_data_empty[i];
      end
    end
  end

  assign last_beat = (beat_cnt == len_q);
  assign w_fire    = (state == DATA) && data_avail && wready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = ADDR;
      ADDR:    if (awready) state_nxt = DATA;
      DATA:    if (w_fire && last_beat) state_nxt = RESP;
      RESP:    if (bvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pop strobes are held off while i_rst is high so a reset never consumes FIFO entries.
  always_comb begin
    awvalid        = 1'b0;
    wvalid         = 1'b0;
    wlast          = 1'b0;
    bready         = 1'b0;
    busy           = (state != IDLE);
    paths_burst_rd = '0;
    paths_data_rd  = '0;
    case (state)
      IDLE: begin
        for (int i = 0; i < P_PATHS; i++) begin
          paths_burst_rd[i] = grant_found && !i_rst && (grant_idx == SEL_W'(i));
        end
      end
      ADDR: awvalid = 1'b1;
      DATA: begin
        wvalid = data_avail;
        wlast  = data_avail && last_beat;
        for (int i = 0; i < P_PATHS; i++) begin
          paths_data_rd[i] = data_avail && wready && !i_rst && (sel == SEL_W'(i));
        end
      end
      RESP: bready = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sel       <= '0;
      rr_ptr    <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      err_bresp <= 1'b0;
    end else begin
      if ((state == IDLE) && grant_found) begin
        sel    <= grant_idx;
        rr_ptr <= rr_nxt;
        addr_q <= grant_desc[39:8];
        len_q  <= grant_desc[7:0];
      end
      if ((state == ADDR) && awready) begin
        beat_cnt <= '0;
      end
      if (w_fire) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      if ((state == RESP) && bvalid && (bresp != 2'b00)) begin
        err_bresp <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      wstrb[4*k +: 4] = {4{dwen_sel[k]}};
    end
  end

  assign wdata   = data_sel;
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = 3'b100;
  assign awburst = 2'b01;
  assign awcache = 4'b0011;
  assign awproto = 3'b000;

endmodule

// File: tb/tb_drc_axi_burst_writer.sv
// tb/tb_drc_axi_burst_writer.sv - self-checking bench for drc_axi_burst_writer
// Queue-based FIFO model plus transaction scoreboard; directed steps then a randomized run.
module tb_drc_axi_burst_writer;
  localparam int P = 2;
  localparam int M_IDLE = 0;
  localparam int M_AW = 1;
  localparam int M_W = 2;
  localparam int M_B = 3;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic [P-1:0]   paths_burst_empty;
  logic [40*P-1:0] paths_burst_in;
  logic [P-1:0]   paths_burst_rd;
  logic [P-1:0]   paths_data_empty;
  logic [128*P-1:0] paths_data_in;
  logic [4*P-1:0] paths_data_dwen;
  logic [P-1:0]   paths_data_rd;
  logic [31:0]    awaddr;
  logic [7:0]     awlen;
  logic [2:0]     awsize;
  logic [1:0]     awburst;
  logic [3:0]     awcache;
  logic [2:0]     awproto;
  logic           awvalid;
  logic           awready;
  logic [127:0]   wdata;
  logic [15:0]    wstrb;
  logic           wlast;
  logic           wvalid;
  logic           wready;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready;
  logic           busy;
  logic           err_bresp;

  drc_axi_burst_writer #(.P_PATHS(P)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .paths_burst_empty(paths_burst_empty), .paths_burst_in(paths_burst_in),
    .paths_burst_rd(paths_burst_rd), .paths_data_empty(paths_data_empty),
    .paths_data_in(paths_data_in), .paths_data_dwen(paths_data_dwen),
    .paths_data_rd(paths_data_rd), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awcache(awcache), .awproto(awproto), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready), .busy(busy),
    .err_bresp(err_bresp)
  );

  always #5 i_clk = ~i_clk;

  logic [39:0]  bmem [P][512];
  logic [131:0] dmem [P][2048];
  int bhead [P];
  int btail [P];
  int dhead [P];
  int dtail [P];
  logic [P-1:0] stall;

  int errors = 0;
  int checks = 0;
  bit rand_mode = 1'b0;
  logic k_rst = 1'b1;
  logic k_awready = 1'b0;
  logic k_wready = 1'b0;
  logic k_bvalid = 1'b0;
  logic [1:0] k_bresp = 2'b00;

  int phase = M_IDLE;
  int rr = 0;
  int cur_p = 0;
  int cur_len = 0;
  int beats = 0;
  logic [31:0] cur_addr = '0;
  bit err_exp = 1'b0;

  int n_aw, n_awv, n_wbeat, n_wlast, n_wlow;
  int n_brd [P];
  int n_drd [P];
  logic [15:0] last_wstrb;
  logic [31:0] last_awaddr;
  int glog [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [P-1:0] oh(input int i);
    logic [P-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] strb(input logic [3:0] dw);
    logic [15:0] s;
    for (int k = 0; k < 4; k++) s[4*k +: 4] = dw[k] ? 4'hF : 4'h0;
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit idle_all();
    bit e;
    e = (phase == M_IDLE);
    for (int i = 0; i < P; i++) if (bhead[i] != btail[i]) e = 1'b0;
    return e;
  endfunction

  task automatic push_desc(input int p, input logic [31:0] a, input logic [7:0] l);
    bmem[p][btail[p]] = {a, l};
    btail[p]++;
  endtask

  task automatic push_beat(input int p, input logic [3:0] dw, input logic [127:0] d);
    dmem[p][dtail[p]] = {dw, d};
    dtail[p]++;
  endtask

  task automatic push_burst(input int p, input logic [31:0] a, input int l);
    push_desc(p, a, 8'(l));
    for (int b = 0; b <= l; b++) push_beat(p, 4'($urandom_range(0, 15)), rnd128());
  endtask

  task automatic clr_stats();
    n_aw = 0; n_awv = 0; n_wbeat = 0; n_wlast = 0; n_wlow = 0;
    last_wstrb = '0; last_awaddr = '0;
    for (int i = 0; i < P; i++) begin n_brd[i] = 0; n_drd[i] = 0; end
    glog.delete();
  endtask

  task automatic drive();
    i_rst   = k_rst;
    awready = rand_mode ? 1'($urandom_range(0, 1)) : k_awready;
    wready  = rand_mode ? 1'($urandom_range(0, 1)) : k_wready;
    bvalid  = rand_mode ? 1'($urandom_range(0, 1)) : k_bvalid;
    bresp   = rand_mode ? (($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00) : k_bresp;
    for (int i = 0; i < P; i++) begin
      stall[i] = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
      paths_burst_empty[i] = (bhead[i] == btail[i]);
      paths_burst_in[40*i +: 40] = bmem[i][bhead[i]];
      paths_data_empty[i] = (dhead[i] == dtail[i]) || stall[i];
      paths_data_in[128*i +: 128] = dmem[i][dhead[i]][127:0];
      paths_data_dwen[4*i +: 4] = dmem[i][dhead[i]][131:128];
    end
  endtask

  task automatic monitor();
    int g;
    bit avail;
    logic [131:0] d;
    if (i_rst) begin
      chk("rd_in_reset", {paths_burst_rd, paths_data_rd}, '0);
      phase = M_IDLE; rr = 0; err_exp = 1'b0;
      for (int i = 0; i < P; i++) begin bhead[i] = btail[i]; dhead[i] = dtail[i]; end
      return;
    end
    chk("busy", busy, phase != M_IDLE);
    chk("err_bresp", err_bresp, err_exp);
    chk("awvalid", awvalid, phase == M_AW);
    chk("bready", bready, phase == M_B);
    case (phase)
      M_IDLE: begin
        g = -1;
        for (int j = 0; j < P; j++) begin
          if (g < 0 && bhead[(rr + j) % P] != btail[(rr + j) % P]) g = (rr + j) % P;
        end
        chk("wvalid_idle", {wvalid, wlast}, 2'b00);
        chk("data_rd_idle", paths_data_rd, '0);
        chk("burst_rd", paths_burst_rd, (g < 0) ? {P{1'b0}} : oh(g));
        if (g >= 0) begin
          cur_addr = bmem[g][bhead[g]][39:8];
          cur_len  = int'(bmem[g][bhead[g]][7:0]);
          bhead[g]++;
          cur_p = g; rr = (g + 1) % P; beats = 0; phase = M_AW;
          glog.push_back(g);
        end
      end
      M_AW: begin
        n_awv++;
        chk("awaddr", awaddr, cur_addr);
        chk("awlen", awlen, cur_len);
        chk("aw_consts", {awsize, awburst, awcache, awproto}, {3'b100, 2'b01, 4'b0011, 3'b000});
        chk("wvalid_aw", wvalid, 1'b0);
        chk("rd_aw", {paths_burst_rd, paths_data_rd}, '0);
        if (awready) begin
          n_aw++; last_awaddr = awaddr; phase = M_W;
        end
      end
      M_W: begin
        avail = (dhead[cur_p] != dtail[cur_p]) && !stall[cur_p];
        chk("wvalid", wvalid, avail);
        chk("burst_rd_w", paths_burst_rd, '0);
        if (avail) begin
          d = dmem[cur_p][dhead[cur_p]];
          chk("wdata", wdata, d[127:0]);
          chk("wstrb", wstrb, strb(d[131:128]));
          chk("wlast", wlast, beats == cur_len);
        end else begin
          n_wlow++;
          chk("wlast_low", wlast, 1'b0);
        end
        if (avail && wready) begin
          chk("data_rd", paths_data_rd, oh(cur_p));
          if (wlast) begin n_wlast++; last_wstrb = wstrb; end
          dhead[cur_p]++; n_wbeat++; beats++;
          if (beats > cur_len) phase = M_B;
        end else begin
          chk("data_rd_hold", paths_data_rd, '0);
        end
      end
      default: begin
        chk("w_resp", {wvalid, paths_burst_rd, paths_data_rd}, '0);
        if (bvalid) begin
          if (bresp != 2'b00) err_exp = 1'b1;
          phase = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic cycle();
    @(negedge i_clk);
    drive();
    #1;
    if (!i_rst) begin
      for (int i = 0; i < P; i++) begin
        n_brd[i] += int'(paths_burst_rd[i]);
        n_drd[i] += int'(paths_data_rd[i]);
      end
    end
    monitor();
  endtask

  task automatic run_idle(input int max);
    int n;
    n = 0;
    while (!idle_all() && n < max) begin cycle(); n++; end
    chk("idle_timeout", idle_all(), 1'b1);
  endtask

  task automatic wait_beats(input int nb, input int max);
    int n;
    n = 0;
    while (!(phase == M_W && beats >= nb) && n < max) begin cycle(); n++; end
    chk("beats_timeout", phase == M_W && beats >= nb, 1'b1);
  endtask

  task automatic wait_aw(input int max);
    int n;
    n = 0;
    while (phase != M_AW && n < max) begin cycle(); n++; end
    chk("aw_timeout", phase == M_AW, 1'b1);
  endtask

  initial begin
    int pushed;
    int exp_beats;
    int len;
    int p;
    for (int i = 0; i < P; i++) begin bhead[i] = 0; btail[i] = 0; dhead[i] = 0; dtail[i] = 0; end
    clr_stats();
    drive();
    cycle();
    cycle();
    k_rst = 1'b0;
    cycle();
    chk("rst_outputs", {awvalid, wvalid, wlast, bready, busy, err_bresp}, 6'b0);
    chk("rst_strobes", {paths_burst_rd, paths_data_rd}, '0);

    // Grant order with both paths preloaded
    k_awready = 1'b1; k_wready = 1'b1; k_bvalid = 1'b1; k_bresp = 2'b00;
    clr_stats();
    for (int k = 0; k < 2; k++) begin
      push_burst(0, 32'h2000_0000 + 32'(k * 16), 0);
      push_burst(1, 32'h3000_0000 + 32'(k * 16), 0);
    end
    run_idle(60);
    chk("t3_grants", glog.size(), 4);
    for (int i = 0; i < 4; i++) chk("t3_grant_order", (i < glog.size()) ? glog[i] : -1, i % 2);
    chk("t3_wlast_every_beat", {n_wlast, n_wbeat}, {32'd4, 32'd4});

    // Basic 4-beat burst with a partial final beat
    clr_stats();
    push_desc(0, 32'h1000_0000, 8'd3);
    for (int b = 0; b < 3; b++) push_beat(0, 4'b1111, rnd128());
    push_beat(0, 4'b0011, rnd128());
    run_idle(50);
    chk("t1_awaddr", last_awaddr, 32'h1000_0000);
    chk("t1_burst_pops", n_brd[0], 1);
    chk("t1_data_pops", n_drd[0], 4);
    chk("t1_wlast_cnt", n_wlast, 1);
    chk("t1_last_wstrb", last_wstrb, 16'h00FF);
    chk("t1_aw_cnt", n_aw, 1);

    // AW backpressure
    clr_stats();
    k_awready = 1'b0;
    push_burst(1, 32'h4000_0100, 1);
    wait_aw(20);
    repeat (5) cycle();
    k_awready = 1'b1;
    run_idle(50);
    chk("t2_awvalid_cycles", n_awv, 6);
    chk("t2_aw_cnt", n_aw, 1);

    // Data FIFO runs dry after the first beat
    clr_stats();
    push_desc(0, 32'h5000_0000, 8'd3);
    push_beat(0, 4'b1111, rnd128());
    wait_beats(1, 30);
    repeat (3) cycle();
    chk("t4_wvalid_low", n_wlow, 3);
    for (int b = 0; b < 3; b++) push_beat(0, 4'b1010, rnd128());
    run_idle(50);
    chk("t4_data_pops", n_drd[0], 4);
    chk("t4_wlast_cnt", n_wlast, 1);
    chk("t4_wvalid_low_total", n_wlow, 3);

    // Sticky BRESP error
    k_bresp = 2'b10;
    push_burst(1, 32'h6000_0000, 1);
    run_idle(50);
    cycle();
    chk("t5_err_set", err_bresp, 1'b1);
    k_bresp = 2'b00;
    clr_stats();
    push_burst(0, 32'h6000_1000, 2);
    run_idle(50);
    cycle();
    chk("t5_err_sticky", err_bresp, 1'b1);
    chk("t5_second_beats", {n_aw, n_wbeat}, {32'd1, 32'd3});

    // Reset in the middle of a burst
    push_burst(0, 32'h7000_0000, 3);
    wait_beats(2, 30);
    k_rst = 1'b1;
    cycle();
    k_rst = 1'b0;
    cycle();
    chk("t6_outputs_after_rst", {awvalid, wvalid, bready, busy, err_bresp}, 5'b0);
    chk("t6_strobes_after_rst", {paths_burst_rd, paths_data_rd}, '0);
    clr_stats();
    push_burst(1, 32'h7100_0000, 1);
    push_burst(0, 32'h7200_0000, 1);
    run_idle(60);
    chk("t6_first_grant", (glog.size() > 0) ? glog[0] : -1, 0);

    // Longest burst
    clr_stats();
    push_burst(1, 32'h8000_0000, 255);
    run_idle(600);
    chk("t7_beats", n_wbeat, 256);
    chk("t7_pops", {n_drd[1], n_wlast}, {32'd256, 32'd1});

    // Randomized traffic, handshakes and stalls
    clr_stats();
    rand_mode = 1'b1;
    pushed = 0;
    exp_beats = 0;
    for (int c = 0; c < 8000 && !(pushed == 40 && idle_all()); c++) begin
      if (pushed < 40 && $urandom_range(0, 3) == 0) begin
        p = $urandom_range(0, P - 1);
        len = $urandom_range(0, 7);
        push_burst(p, $urandom & 32'hFFFF_FFF0, len);
        exp_beats += len + 1;
        pushed++;
      end
      cycle();
    end
    rand_mode = 1'b0;
    chk("rand_done", pushed == 40 && idle_all(), 1'b1);
    chk("rand_aw_cnt", n_aw, 40);
    chk("rand_beats", n_wbeat, exp_beats);
    chk("rand_wlast_cnt", n_wlast, 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/drc_axi_burst_writer.md
Name: drc_axi_burst_writer

Overview:
Downstream drain stage of the DMA read controller. Arbitrates round-robin over P_PATHS per-path burst-descriptor and data FIFOs, issues one AXI4 INCR write burst per descriptor, and streams the matching 128-bit data beats to device memory. Only one burst is outstanding at a time. BRESP errors are flagged stickily.

Parameters:
P_PATHS, 2, number of path FIFO pairs (1..8)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
paths_burst_empty  in  P_PATHS  per-path burst FIFO empty
paths_burst_in  in  40*P_PATHS  per-path descriptor {addr[31:0], len[7:0]}; path i at [40*i+39:40*i]
paths_burst_rd  out  P_PATHS  burst FIFO pop strobe
paths_data_empty  in  P_PATHS  per-path data FIFO empty
paths_data_in  in  128*P_PATHS  per-path data beat
paths_data_dwen  in  4*P_PATHS  per-path dword enables for the head beat
paths_data_rd  out  P_PATHS  data FIFO pop strobe
awaddr  out  32  burst address
awlen  out  8  beats-1
awsize  out  3  constant 3'b100
awburst  out  2  constant 2'b01
awcache  out  4  constant 4'b0011
awproto  out  3  constant 3'b000
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  128  write data
wstrb  out  16  byte strobes
wlast  out  1  last beat
wvalid  out  1  W valid
wready  in  1  W ready
bresp  in  2  write response
bvalid  in  1  B valid
bready  out  1  B ready
busy  out  1  high whenever state != IDLE
err_bresp  out  1  sticky: some bresp != 2'b00

Behaviour:
- Reset: i_clk is the clock; i_rst is synchronous, active-high. On reset: state=IDLE; awvalid, wvalid, wlast, bready, busy, err_bresp = 0; all rd strobes = 0; rr_ptr=0; beat_cnt=0.
- FIFOs are show-ahead: head entry is valid on *_in whenever !empty. An rd pulse pops the entry; the next entry is visible the following cycle.
- Descriptor len is the AXI awlen directly; burst length = len+1 beats. Upstream guarantees no 4 KB crossing, and that the data FIFO receives exactly len+1 beats for each descriptor, in order.
- States:
  - IDLE: scan paths starting at rr_ptr, wrapping modulo P_PATHS. On the first i with !paths_burst_empty[i]:
    - set sel=i;
    - latch addr and len into registers;
    - pulse paths_burst_rd[i] for exactly 1 cycle;
    - set rr_ptr=(i+1) mod P_PATHS;
    - go to ADDR.
    If all paths are empty, stay in IDLE.
  - ADDR: awvalid=1, with awaddr/awlen from the latches held stable. On awready, go to DATA with beat_cnt=0. Latency: awvalid rises the cycle after the grant.
  - DATA:
    - wvalid = !paths_data_empty[sel].
    - wdata = paths_data_in[sel].
    - wstrb[4k+3:4k] = {4{dwen[sel][k]}}.
    - wlast = wvalid && beat_cnt==len.
    - On wvalid&&wready: paths_data_rd[sel] is asserted combinationally in the same cycle; beat_cnt increments. If wlast, go to RESP.
    - When the data FIFO is empty mid-burst, wvalid drops and no beat is consumed; beat_cnt is held.
  - RESP: bready=1. On bvalid, go to IDLE; if bresp != 0, set err_bresp=1 (cleared only by reset).
- IDLE may grant in the cycle after the B handshake, so there is a 1-cycle IDLE bubble between bursts.
- W beats are never issued before the AW handshake.
- wready may be high while wvalid is low; no effect.
- bvalid outside RESP is ignored (bready=0).
- All pop strobes are one-hot or zero.
- Reset mid-burst: immediate return to IDLE, no further pops, outputs drop per the reset list. FIFO content is not recovered.
- beat_cnt is 8-bit; len=255 gives 256 beats with no overflow side effects.
- P_PATHS=1: rr_ptr is always 0.

Test Plan:
- Path0 descriptor {0x1000_0000, 3}; 4 beats with dwen 1111,1111,1111,0011 -> awaddr=0x10000000, awlen=3, awsize=4, awburst=1. 4 W beats; last has wstrb=0x00FF and wlast=1. paths_burst_rd[0] pulses once; paths_data_rd[0] pulses 4 times.
- awready held low 5 cycles, then high -> awaddr/awlen/awvalid stable for 6 cycles; wvalid=0 throughout; exactly 1 AW handshake.
- Both paths preloaded with 2 descriptors each (len=0), all ready high -> grant order path0, path1, path0, path1; wlast asserted on every beat.
- Data FIFO empty for 3 cycles after beat 1 of a len=3 burst -> wvalid=0 for those 3 cycles; wlast only on the 4th accepted beat; no extra pops.
- bresp=2'b10 on first burst, then a second burst -> err_bresp=1 from that cycle and still 1 after the second burst; the second burst completes normally.
- i_rst asserted after 2 of 4 beats -> next cycle awvalid=wvalid=bready=busy=0 and no rd strobes; after release, the next descriptor is taken from path0.
